// File: rtl/edge_detect_multi_pkg.sv
// Shared mode encoding for the multi-channel edge detector.
// Each channel selects which accepted edges drive its pulse output.
package edge_detect_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  function automatic logic mode_hit(mode_t m, logic rise_ev, logic fall_ev);
    logic rise_en;
    logic fall_en;
    rise_en = (m == MODE_RISE) || (m == MODE_BOTH);
    fall_en = (m == MODE_FALL) || (m == MODE_BOTH);
    return (rise_ev && rise_en) || (fall_ev && fall_en);
  endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
// Level inputs, controls and event outputs of the multi-channel edge detector.
// master drives inputs and observes events; slave is the detector itself.
interface edge_detect_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   data_in;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   flag_clr;
  logic [CHANNELS-1:0]   level_o;
  logic [CHANNELS-1:0]   rise;
  logic [CHANNELS-1:0]   fall;
  logic [CHANNELS-1:0]   pulse;
  logic [CHANNELS-1:0]   flag;
  logic                  irq;

  modport master (
    output data_in, mode, flag_clr,
    input  level_o, rise, fall, pulse, flag, irq
  );

  modport slave (
    input  data_in, mode, flag_clr,
    output level_o, rise, fall, pulse, flag, irq
  );
endinterface

// File: rtl/edge_detect_multi_chan.sv
// One channel: optional synchroniser, debounce counter, accepted level and
// combinational rise/fall next-state that the top level registers.
module edge_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_next,
  output logic fall_next
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync_out;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_p;

      // synchroniser chain, stage 0 samples the raw input
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_p <= '0;
        end else begin
          sync_p[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_p[k] <= sync_p[k-1];
          end
        end
      end

      assign sync_out = sync_p[SYNC_STAGES-1];
    end
  endgenerate

  assign differ    = (sync_out != level);
  assign accept    = differ && (cnt == CNT_LAST);
  assign rise_next = accept && sync_out;
  assign fall_next = accept && !sync_out;

  // a return to the accepted level before the count completes drops the change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (accept) begin
      level <= sync_out;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector: per-channel filters, registered
// rise/fall/mode-gated pulse outputs, sticky flags and a combined interrupt.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input logic               clk,
  input logic               rst,
  edge_detect_multi_if.slave bus
);
  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;
  logic [CHANNELS-1:0] pulse_next;
  logic [CHANNELS-1:0] flag_next;

  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] flag_q;
  logic                irq_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din      (bus.data_in[i]),
      .level    (level_w[i]),
      .rise_next(rise_next[i]),
      .fall_next(fall_next[i])
    );

    // mode is only looked at on the accept cycle, so changing it is harmless
    assign pulse_next[i] = mode_hit(mode_t'(bus.mode[2*i +: 2]), rise_next[i], fall_next[i]);
  end

  // a set on the same edge as a clear wins, so no event is lost
  assign flag_next = pulse_next | (flag_q & ~bus.flag_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q  <= '0;
      fall_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      rise_q  <= rise_next;
      fall_q  <= fall_next;
      pulse_q <= pulse_next;
      flag_q  <= flag_next;
      irq_q   <= |flag_next;
    end
  end

  assign bus.level_o = level_w;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.pulse   = pulse_q;
  assign bus.flag    = flag_q;
  assign bus.irq     = irq_q;

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised multi-channel successor to the single-bit level-to-pulse detector.
- Each channel has:
  - an optional input synchroniser;
  - a debounce (glitch) filter;
  - registered single-cycle rise, fall and mode-gated pulse outputs;
  - a sticky event flag with clear.
- The OR of all flags drives one interrupt line.
- Sits between asynchronous or noisy level inputs (buttons, status lines) and control logic or an interrupt controller.

Parameters:
- CHANNELS, 4: number of independent channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, 0..4. 0 means the input is already synchronous to clk.
- DEBOUNCE, 4: consecutive cycles a changed level must persist before it is accepted, 1..65535. 1 means no filtering.

Ports:
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- data_in  in  CHANNELS: raw level inputs.
- mode  in  2*CHANNELS: per-channel mode; channel i uses bits [2i+1:2i].
- flag_clr  in  CHANNELS: per-channel sticky-flag clear, sampled each cycle.
- level_o  out  CHANNELS: filtered (accepted) level.
- rise  out  CHANNELS: one-cycle pulse on accepted 0->1; not gated by mode.
- fall  out  CHANNELS: one-cycle pulse on accepted 1->0; not gated by mode.
- pulse  out  CHANNELS: one-cycle pulse on a mode-selected edge.
- flag  out  CHANNELS: sticky event flag.
- irq  out  1: OR of all flag bits, registered.

Behaviour:
- Reset clears the following to 0: all synchroniser flops, accepted level, debounce counters, level_o, rise, fall, pulse, flag and irq. No reset value depends on data_in.
- Synchroniser: a chain of SYNC_STAGES flops per channel. sync_out is the last stage, or data_in when SYNC_STAGES=0.
- Debounce: per-channel counter cnt, width clog2(DEBOUNCE+1).
  - If sync_out == level: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: level <= sync_out and cnt <= 0. This is the accept event.
  - Else: cnt <= cnt+1.
  - If sync_out returns to level before the count completes, cnt returns to 0 and no edge is produced (glitch rejected).
- Edge outputs are registered at the accept edge, so they are visible in the same cycle as the new level_o:
  - rise <= accept && sync_out==1;
  - fall <= accept && sync_out==0;
  - otherwise both are 0 (never more than 1 cycle high).
- Latency: if data_in changes between edge 0 and edge 1 and stays stable, the accept occurs at edge SYNC_STAGES+DEBOUNCE. rise/fall/level_o are high from that edge. Defaults: 6 cycles.
- Mode encoding per channel:
  - 00 OFF: pulse never asserts;
  - 01 RISE;
  - 10 FALL;
  - 11 BOTH.
- pulse <= (rise_next && mode[0]) || (fall_next && mode[1]), registered in the same cycle as rise/fall.
- mode is sampled at the accept edge. A mode change never disturbs the filter state or level_o.
- Flags:
  - flag[i] <= 1 when pulse_next[i];
  - else flag[i] <= 0 when flag_clr[i];
  - else flag[i] holds.
  - A simultaneous set and clear leaves flag=1, so no event is lost.
- irq <= |flag_next, i.e. irq tracks flag in the same cycle.
- Channels are fully independent; simultaneous events on any subset are all reported.
- Reset asserted mid-count discards the pending change. After release, the filter restarts from level 0 and the current sync_out.

Decomposition:
- Shared package edge_detect_pkg:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - mode_t 2-bit typedef.
- Sub-module edge_chan: one channel containing the synchroniser, debounce counter, level and accept/rise/fall next-state.
  - Generated CHANNELS times.
- The top level holds mode gating, output registers, flags and irq.

Test Plan (defaults CHANNELS=4, SYNC_STAGES=2, DEBOUNCE=4):
1. Reset with data_in=4'hF held across release, mode all 11 -> all outputs 0 during reset. rise=4'hF, pulse=4'hF, level_o=4'hF 6 cycles after the first post-reset edge, each pulse exactly 1 cycle wide. flag=4'hF and irq=1 in the same cycle.
2. Glitch on ch0: high for 3 cycles then low -> no rise, level_o[0]=0. High for 4 cycles -> rise[0] for exactly 1 cycle, 6 edges after the change.
3. Mode ch1=01, ch2=10, ch3=00: toggle all high then low (each held 10 cycles) ->
   - rise and fall fire on all three channels;
   - pulse[1] only on rise, pulse[2] only on fall, pulse[3] never;
   - flag[3] stays 0.
4. Flags: set flag[0], pulse flag_clr[0] -> flag[0]=0 next cycle and irq drops. Then set and clear on the same edge -> flag[0]=1, irq=1.
5. Reset mid-operation: ch0 change in progress with cnt=2, assert rst 1 cycle -> cnt, level and flags are 0, and no rise is emitted for the aborted count. After release, data_in[0]=1 still held -> rise after 6 cycles.
6. Simultaneous opposite events: ch0 rising and ch1 falling accepted on the same edge -> rise=4'b0001, fall=4'b0010, both for 1 cycle; both flags set with mode 11.
